// File: rtl/eth_avalon_bd_arbiter.sv
// ---------------------------------------------------------------------------
// eth_avalon_bd_arbiter
//
// Shares port A of the 32-bit buffer-descriptor RAM between three requesters:
// the CPU (Avalon slave side), the TX descriptor DMA and the RX descriptor DMA.
//
// Arbitration:
//   - The CPU wins whenever it requests, unless a DMA is waiting and the CPU
//     has already taken CPU_BURST_MAX consecutive grants.
//   - TX and RX alternate when both request; TX wins the first tie after
//     reset.
//   - At most one grant per cycle. Grants are combinational.
//
// The RAM registers its address and drives ram_q combinationally from that
// registered address. A read granted in cycle N therefore has data on ram_q
// in cycle N+1, which is when the matching *_rvalid is raised.
//
// Ports:
//   clock, reset_n                 clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata          CPU access request
//   cpu_gnt, cpu_rvalid            CPU grant (comb), read data valid (N+1)
//   tx_*  / rx_*                   same set for the TX and RX DMA engines
//   rdata                          shared read data (= ram_q)
//   ram_wren/address/data          BD RAM port A drive
//   ram_q                          BD RAM port A read data
// ---------------------------------------------------------------------------
module eth_avalon_bd_arbiter #(
    parameter int DEPTH         = 128,
    parameter int CPU_BURST_MAX = 4,
    parameter int AW            = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic          clock,
    input  logic          reset_n,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,

    input  logic          tx_req,
    input  logic          tx_we,
    input  logic [AW-1:0] tx_addr,
    input  logic [31:0]   tx_wdata,
    output logic          tx_gnt,
    output logic          tx_rvalid,

    input  logic          rx_req,
    input  logic          rx_we,
    input  logic [AW-1:0] rx_addr,
    input  logic [31:0]   rx_wdata,
    output logic          rx_gnt,
    output logic          rx_rvalid,

    output logic [31:0]   rdata,

    output logic          ram_wren,
    output logic [AW-1:0] ram_address,
    output logic [31:0]   ram_data,
    input  logic [31:0]   ram_q
);

    localparam int         NREQ      = 3;
    localparam int         IDX_CPU   = 0;
    localparam int         IDX_TX    = 1;
    localparam int         IDX_RX    = 2;
    localparam logic [3:0] BURST_MAX = 4'(CPU_BURST_MAX);

    typedef enum logic {
        DMA_TX = 1'b0,
        DMA_RX = 1'b1
    } dma_sel_t;

    // Requester vectors, indexed CPU/TX/RX, so the RAM mux and the
    // read-valid pipeline treat all three requesters uniformly.
    logic [NREQ-1:0] req_vec;
    logic [NREQ-1:0] we_vec;
    logic [NREQ-1:0] gnt_vec;
    logic [AW-1:0]   addr_vec  [NREQ];
    logic [31:0]     wdata_vec [NREQ];

    assign req_vec = {rx_req, tx_req, cpu_req};
    assign we_vec  = {rx_we,  tx_we,  cpu_we};

    assign addr_vec[IDX_CPU]  = cpu_addr;
    assign addr_vec[IDX_TX]   = tx_addr;
    assign addr_vec[IDX_RX]   = rx_addr;
    assign wdata_vec[IDX_CPU] = cpu_wdata;
    assign wdata_vec[IDX_TX]  = tx_wdata;
    assign wdata_vec[IDX_RX]  = rx_wdata;

    // State
    logic [3:0]      cpu_cnt_reg;
    logic [3:0]      cpu_cnt_next;
    dma_sel_t        last_dma_reg;
    dma_sel_t        last_dma_next;
    logic [NREQ-1:0] rvalid_reg;

    logic dma_pend;
    logic cpu_win;

    // -----------------------------------------------------------------------
    // Grant decision
    // -----------------------------------------------------------------------
    assign dma_pend = tx_req | rx_req;
    assign cpu_win  = cpu_req & (~dma_pend | (cpu_cnt_reg < BURST_MAX));

    always_comb begin
        gnt_vec = '0;
        if (cpu_win) begin
            gnt_vec[IDX_CPU] = 1'b1;
        end else if (tx_req && rx_req) begin
            // Tie: the DMA that was not served last goes next.
            if (last_dma_reg == DMA_RX) begin
                gnt_vec[IDX_TX] = 1'b1;
            end else begin
                gnt_vec[IDX_RX] = 1'b1;
            end
        end else if (tx_req) begin
            gnt_vec[IDX_TX] = 1'b1;
        end else if (rx_req) begin
            gnt_vec[IDX_RX] = 1'b1;
        end
    end

    assign cpu_gnt = gnt_vec[IDX_CPU];
    assign tx_gnt  = gnt_vec[IDX_TX];
    assign rx_gnt  = gnt_vec[IDX_RX];

    // -----------------------------------------------------------------------
    // Burst counter and DMA round-robin pointer
    // -----------------------------------------------------------------------
    always_comb begin
        cpu_cnt_next  = cpu_cnt_reg;
        last_dma_next = last_dma_reg;

        // The counter only measures CPU grants taken while a DMA is
        // waiting; any DMA service or an idle DMA side restarts it.
        if (!dma_pend || gnt_vec[IDX_TX] || gnt_vec[IDX_RX]) begin
            cpu_cnt_next = '0;
        end else if (gnt_vec[IDX_CPU] && (cpu_cnt_reg < BURST_MAX)) begin
            cpu_cnt_next = cpu_cnt_reg + 4'd1;
        end

        if (gnt_vec[IDX_TX]) begin
            last_dma_next = DMA_TX;
        end else if (gnt_vec[IDX_RX]) begin
            last_dma_next = DMA_RX;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cpu_cnt_reg  <= '0;
            last_dma_reg <= DMA_RX;
            rvalid_reg   <= '0;
        end else begin
            cpu_cnt_reg  <= cpu_cnt_next;
            last_dma_reg <= last_dma_next;
            // ram_q is valid the cycle after the RAM captured the address,
            // so a read grant turns into rvalid exactly one cycle later.
            rvalid_reg   <= gnt_vec & ~we_vec;
        end
    end

    assign cpu_rvalid = rvalid_reg[IDX_CPU];
    assign tx_rvalid  = rvalid_reg[IDX_TX];
    assign rx_rvalid  = rvalid_reg[IDX_RX];
    assign rdata      = ram_q;

    // -----------------------------------------------------------------------
    // RAM port drive: the granted requester's signals, all-zero when idle.
    // -----------------------------------------------------------------------
    always_comb begin
        ram_wren    = 1'b0;
        ram_address = '0;
        ram_data    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_vec[i]) begin
                ram_wren    = we_vec[i];
                ram_address = addr_vec[i];
                ram_data    = wdata_vec[i];
            end
        end
    end

endmodule

// File: tb/tb_eth_avalon_bd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_eth_avalon_bd_arbiter
//
// Directed bench for eth_avalon_bd_arbiter. Includes a behavioural BD RAM
// (registered address, combinational q) preloaded with 32'hC0DE_0000 | addr.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_eth_avalon_bd_arbiter;

    localparam int AW = 7;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          cpu_req, cpu_we, tx_req, tx_we, rx_req, rx_we;
    logic [AW-1:0] cpu_addr, tx_addr, rx_addr;
    logic [31:0]   cpu_wdata, tx_wdata, rx_wdata;
    logic          cpu_gnt, cpu_rvalid, tx_gnt, tx_rvalid, rx_gnt, rx_rvalid;
    logic [31:0]   rdata;
    logic          ram_wren;
    logic [AW-1:0] ram_address;
    logic [31:0]   ram_data;
    logic [31:0]   ram_q;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    eth_avalon_bd_arbiter #(
        .DEPTH         (128),
        .CPU_BURST_MAX (4)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .cpu_rvalid  (cpu_rvalid),
        .tx_req      (tx_req),
        .tx_we       (tx_we),
        .tx_addr     (tx_addr),
        .tx_wdata    (tx_wdata),
        .tx_gnt      (tx_gnt),
        .tx_rvalid   (tx_rvalid),
        .rx_req      (rx_req),
        .rx_we       (rx_we),
        .rx_addr     (rx_addr),
        .rx_wdata    (rx_wdata),
        .rx_gnt      (rx_gnt),
        .rx_rvalid   (rx_rvalid),
        .rdata       (rdata),
        .ram_wren    (ram_wren),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_q       (ram_q)
    );

    // Behavioural BD RAM port A
    logic [31:0]   mem [128];
    logic [AW-1:0] ram_addr_q = '0;
    logic          preloaded  = 1'b0;

    always @(posedge clock) begin
        if (!preloaded) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
            preloaded <= 1'b1;
        end else if (ram_wren) begin
            mem[ram_address] <= ram_data;
        end
        ram_addr_q <= ram_address;
    end
    assign ram_q = mem[ram_addr_q];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Hand-derived expected sequences
    logic [1:0] t3_gnt [7] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00};
    logic [1:0] t3_val [7] = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    logic [1:0] t4_gnt [10] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01,
                                2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    logic [2:0] t5_gnt [5] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b010};

    initial begin
        logic [1:0] prev;
        reset_n  = 1'b0;
        cpu_req  = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        tx_req   = 0; tx_we  = 0; tx_addr  = '0; tx_wdata  = '0;
        rx_req   = 0; rx_we  = 0; rx_addr  = '0; rx_wdata  = '0;

        // 1. Idle in/after reset
        @(negedge clock);
        check("rst_gnt",    {cpu_gnt, tx_gnt, rx_gnt}, 3'b000);
        check("rst_rvalid", {cpu_rvalid, tx_rvalid, rx_rvalid}, 3'b000);
        check("rst_wren",   ram_wren, 1'b0);
        check("rst_addr",   ram_address, 7'd0);
        tick();
        reset_n = 1'b1;
        tick();
        $display("step 1: idle after reset");

        // 2. CPU write 0xDEADBEEF @5 then read @5
        cpu_req = 1; cpu_we = 1; cpu_addr = 7'd5; cpu_wdata = 32'hDEADBEEF;
        @(negedge clock);
        check("t2_wr_gnt",  cpu_gnt, 1'b1);
        check("t2_wr_wren", ram_wren, 1'b1);
        check("t2_wr_addr", ram_address, 7'd5);
        check("t2_wr_data", ram_data, 32'hDEADBEEF);
        tick();
        cpu_we = 0;
        @(negedge clock);
        check("t2_rd_gnt",    cpu_gnt, 1'b1);
        check("t2_rd_wren",   ram_wren, 1'b0);
        check("t2_wr_norval", cpu_rvalid, 1'b0);
        tick();
        cpu_req = 0;
        @(negedge clock);
        check("t2_rvalid", cpu_rvalid, 1'b1);
        check("t2_rdata",  rdata, 32'hDEADBEEF);
        check("t2_idle",   cpu_gnt, 1'b0);
        tick();
        @(negedge clock);
        check("t2_rvalid_off", cpu_rvalid, 1'b0);
        tick();
        $display("step 2: cpu write then read @5");

        // 3. TX and RX reads held together -> alternate, TX first
        tx_req = 1; tx_we = 0; tx_addr = 7'd10;
        rx_req = 1; rx_we = 0; rx_addr = 7'd20;
        for (int k = 0; k < 7; k++) begin
            if (k == 6) begin
                tx_req = 0; rx_req = 0;
            end
            @(negedge clock);
            check($sformatf("t3_gnt%0d", k), {tx_gnt, rx_gnt}, t3_gnt[k]);
            check($sformatf("t3_val%0d", k), {tx_rvalid, rx_rvalid}, t3_val[k]);
            if (t3_val[k] == 2'b10) check($sformatf("t3_txd%0d", k), rdata, 32'hC0DE_000A);
            if (t3_val[k] == 2'b01) check($sformatf("t3_rxd%0d", k), rdata, 32'hC0DE_0014);
            tick();
        end
        $display("step 3: tx/rx round robin");

        // 4. CPU and TX held -> 4 CPU grants, then TX, repeating
        cpu_req = 1; cpu_we = 0; cpu_addr = 7'd5;
        tx_req  = 1; tx_we  = 0; tx_addr  = 7'd10;
        prev = 2'b00;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            check($sformatf("t4_gnt%0d", k), {cpu_gnt, tx_gnt, rx_gnt}, {t4_gnt[k], 1'b0});
            check($sformatf("t4_val%0d", k), {cpu_rvalid, tx_rvalid}, prev);
            if (prev == 2'b10) check($sformatf("t4_cpud%0d", k), rdata, 32'hDEADBEEF);
            prev = t4_gnt[k];
            tick();
        end
        cpu_req = 0; tx_req = 0;
        @(negedge clock);
        check("t4_tail_val", {cpu_rvalid, tx_rvalid}, prev);
        check("t4_tail_txd", rdata, 32'hC0DE_000A);
        tick();
        $display("step 4: cpu burst limit");

        // 5. Reset while a CPU read is granted (last_dma=TX, cpu_cnt=2)
        cpu_req = 1; tx_req = 1;
        @(negedge clock);
        check("t5_pre0", {cpu_gnt, tx_gnt}, 2'b10);
        tick();
        @(negedge clock);
        check("t5_pre1", {cpu_gnt, tx_gnt}, 2'b10);
        tick();
        @(negedge clock);
        check("t5_pre2", {cpu_gnt, tx_gnt}, 2'b10);
        reset_n = 1'b0; cpu_req = 0; tx_req = 0;
        #2;
        check("t5_rst_rvalid", cpu_rvalid, 1'b0);
        reset_n = 1'b1;
        tick();
        @(negedge clock);
        check("t5_no_rvalid", {cpu_rvalid, tx_rvalid, rx_rvalid}, 3'b000);
        tick();
        cpu_req = 1; tx_req = 1; rx_req = 1; rx_addr = 7'd20;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check($sformatf("t5_gnt%0d", k), {cpu_gnt, tx_gnt, rx_gnt}, t5_gnt[k]);
            tick();
        end
        cpu_req = 0; tx_req = 0; rx_req = 0;
        tick();
        $display("step 5: reset discards read, restores arbitration state");

        // 6. DMA writes, read back by CPU; cancelled RX request
        tx_req = 1; tx_we = 1; tx_addr = 7'd30; tx_wdata = 32'h12345678;
        @(negedge clock);
        check("t6_tx_gnt",  {cpu_gnt, tx_gnt, rx_gnt}, 3'b010);
        check("t6_tx_bus",  {ram_wren, ram_address, ram_data}, {1'b1, 7'd30, 32'h12345678});
        tick();
        tx_req = 0;
        rx_req = 1; rx_we = 1; rx_addr = 7'd31; rx_wdata = 32'hCAFEF00D;
        @(negedge clock);
        check("t6_rx_gnt",  {cpu_gnt, tx_gnt, rx_gnt}, 3'b001);
        check("t6_rx_bus",  {ram_wren, ram_address, ram_data}, {1'b1, 7'd31, 32'hCAFEF00D});
        check("t6_wr_noval", {tx_rvalid, rx_rvalid}, 2'b00);
        tick();
        rx_req = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 7'd30;
        @(negedge clock);
        check("t6_rd30_gnt", cpu_gnt, 1'b1);
        tick();
        cpu_addr = 7'd31;
        rx_req = 1; rx_we = 1; rx_wdata = 32'h0;
        @(negedge clock);
        check("t6_rd30_data", {cpu_rvalid, rdata}, {1'b1, 32'h12345678});
        check("t6_rx_wait",   {cpu_gnt, rx_gnt}, 2'b10);
        tick();
        rx_req = 0; cpu_req = 0;
        @(negedge clock);
        check("t6_rd31_data", {cpu_rvalid, rdata}, {1'b1, 32'hCAFEF00D});
        check("t6_rx_cancel", {rx_gnt, rx_rvalid, ram_wren}, 3'b000);
        tick();
        $display("step 6: dma writes, cpu readback, cancelled rx");

        // Idle bus after traffic
        cpu_addr = 7'd9; cpu_wdata = 32'hFFFF_FFFF;
        @(negedge clock);
        check("idle_bus", {ram_wren, ram_address, ram_data}, 40'd0);
        check("idle_val", {cpu_rvalid, tx_rvalid, rx_rvalid}, 3'b000);
        tick();
        $display("step 7: idle bus");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the bench can never hang
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
